// File: rtl/seq_pkg.sv
// Shared constants for the microcoded sequencer: opcodes, control-word bit
// positions, the fixed fetch/execute words and small one-hot helpers.
package seq_pkg;

  localparam int CW_BITS     = 15;
  localparam int CW_W_MIN    = 15;
  localparam int OP_W_MIN    = 4;
  localparam int T_MAX_MIN   = 5;
  localparam int T_MAX_LIMIT = 32;

  typedef logic [CW_BITS-1:0] cw_t;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_STA = 4'h3;
  localparam logic [3:0] OP_LDI = 4'h4;
  localparam logic [3:0] OP_JMP = 4'h5;
  localparam logic [3:0] OP_JC  = 4'h6;
  localparam logic [3:0] OP_JZ  = 4'h7;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam int CW_PC_INC  = 0;
  localparam int CW_PC_OUT  = 1;
  localparam int CW_PC_LD   = 2;
  localparam int CW_MAR_LD  = 3;
  localparam int CW_RAM_OUT = 4;
  localparam int CW_RAM_IN  = 5;
  localparam int CW_IR_LD   = 6;
  localparam int CW_IR_OUT  = 7;
  localparam int CW_A_LD    = 8;
  localparam int CW_A_OUT   = 9;
  localparam int CW_B_LD    = 10;
  localparam int CW_ALU_OUT = 11;
  localparam int CW_ALU_SUB = 12;
  localparam int CW_OUT_LD  = 13;
  localparam int CW_HLT     = 14;

  function automatic cw_t cw_bit(input int idx);
    return cw_t'(15'd1) << idx;
  endfunction

  localparam cw_t CW_IDLE    = 15'h0000;
  localparam cw_t CW_FETCH1  = cw_bit(CW_PC_OUT) | cw_bit(CW_MAR_LD);
  localparam cw_t CW_FETCH2  = cw_bit(CW_RAM_OUT) | cw_bit(CW_IR_LD) | cw_bit(CW_PC_INC);
  localparam cw_t CW_ADDR    = cw_bit(CW_IR_OUT) | cw_bit(CW_MAR_LD);
  localparam cw_t CW_MEM_A   = cw_bit(CW_RAM_OUT) | cw_bit(CW_A_LD);
  localparam cw_t CW_MEM_B   = cw_bit(CW_RAM_OUT) | cw_bit(CW_B_LD);
  localparam cw_t CW_ALU_A   = cw_bit(CW_ALU_OUT) | cw_bit(CW_A_LD);
  localparam cw_t CW_ALU_SA  = CW_ALU_A | cw_bit(CW_ALU_SUB);
  localparam cw_t CW_STORE   = cw_bit(CW_A_OUT) | cw_bit(CW_RAM_IN);
  localparam cw_t CW_IMM_A   = cw_bit(CW_IR_OUT) | cw_bit(CW_A_LD);
  localparam cw_t CW_JUMP    = cw_bit(CW_IR_OUT) | cw_bit(CW_PC_LD);
  localparam cw_t CW_OUTPUT  = cw_bit(CW_A_OUT) | cw_bit(CW_OUT_LD);
  localparam cw_t CW_HALT    = cw_bit(CW_HLT);

  function automatic logic is_onehot(input logic [T_MAX_LIMIT-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < T_MAX_LIMIT; i++) n += 32'(v[i]);
    return n == 32'd1;
  endfunction

  function automatic int unsigned oh_index(input logic [T_MAX_LIMIT-1:0] v);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < T_MAX_LIMIT; i++) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

  // Execute-phase length; undecodable opcodes behave as a one-step NOP.
  function automatic int unsigned exec_len(input logic [3:0] op, input logic op_ok);
    int unsigned len;
    len = 1;
    if (op_ok) begin
      case (op)
        OP_LDA, OP_STA: len = 2;
        OP_ADD, OP_SUB: len = 3;
        default:        len = 1;
      endcase
    end else begin
      len = 1;
    end
    return len;
  endfunction

endpackage

// File: rtl/seq_ring_counter.sv
// One-hot T-state ring: sync reset to T1, hold, reload T1, clear for halt.
module seq_ring_counter #(
  parameter int T_MAX = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load_t1,
  input  logic             clear,
  output logic [T_MAX-1:0] t_state
);

  localparam logic [T_MAX-1:0] T1 = {{(T_MAX-1){1'b0}}, 1'b1};

  logic [T_MAX-1:0] ring_r;

  // Ring register; clear beats reload, reload beats rotate.
  always_ff @(posedge clk) begin
    if (rst) begin
      ring_r <= T1;
    end else if (en) begin
      if (clear) begin
        ring_r <= {T_MAX{1'b0}};
      end else if (load_t1) begin
        ring_r <= T1;
      end else begin
        ring_r <= {ring_r[T_MAX-2:0], ring_r[T_MAX-1]};
      end
    end else begin
      ring_r <= ring_r;
    end
  end

  assign t_state = ring_r;

endmodule

// File: rtl/microcoded_sequencer.sv
// SAP-class control sequencer: decodes the T-state ring, opcode and flags into
// the datapath control word, and keeps a sticky halt flag.
module microcoded_sequencer
  import seq_pkg::*;
#(
  parameter int CW_W  = 16,
  parameter int OP_W  = 4,
  parameter int T_MAX = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic [OP_W-1:0] opcode,
  input  logic            flag_c,
  input  logic            flag_z,
  output logic [CW_W-1:0] con_word,
  output logic [T_MAX-1:0] t_state,
  output logic            instr_done,
  output logic            halted
);

  if (CW_W < CW_W_MIN) begin : g_cw_w_check
    $error("microcoded_sequencer: CW_W must be at least 15");
  end
  if (OP_W < OP_W_MIN) begin : g_op_w_check
    $error("microcoded_sequencer: OP_W must be at least 4");
  end
  if (T_MAX < T_MAX_MIN || T_MAX > T_MAX_LIMIT) begin : g_t_max_check
    $error("microcoded_sequencer: T_MAX must be in 5..32");
  end

  logic [T_MAX-1:0] t_state_s;
  logic             halted_r;
  logic             adv_s;
  logic             op_ok_s;
  logic [3:0]       op4_s;
  logic [T_MAX_LIMIT-1:0] ts_ext_s;
  cw_t              cw_s;
  logic             done_s;
  logic             illegal_s;
  logic             halt_step_s;
  int unsigned      step_s;
  int unsigned      estep_s;
  int unsigned      elen_s;

  assign adv_s    = run & ~halted_r;
  assign op_ok_s  = (opcode >> 32'd4) == {OP_W{1'b0}};
  assign op4_s    = opcode[3:0];
  assign ts_ext_s = T_MAX_LIMIT'(t_state_s);

  seq_ring_counter #(.T_MAX(T_MAX)) u_ring (
    .clk     (clk),
    .rst     (rst),
    .en      (adv_s),
    .load_t1 (done_s | illegal_s),
    .clear   (halt_step_s),
    .t_state (t_state_s)
  );

  // Microcode decode; a non-one-hot ring or a step past the instruction end is illegal.
  always_comb begin
    cw_s        = CW_IDLE;
    done_s      = 1'b0;
    illegal_s   = 1'b0;
    halt_step_s = 1'b0;
    step_s      = oh_index(ts_ext_s);
    elen_s      = exec_len(op4_s, op_ok_s);
    estep_s     = 0;
    if (!is_onehot(ts_ext_s)) begin
      illegal_s = 1'b1;
    end else if (step_s == 32'd0) begin
      cw_s = CW_FETCH1;
    end else if (step_s == 32'd1) begin
      cw_s = CW_FETCH2;
    end else if ((step_s - 32'd2) >= elen_s) begin
      illegal_s = 1'b1;
    end else begin
      estep_s = step_s - 32'd2;
      done_s  = (estep_s == (elen_s - 32'd1));
      if (!op_ok_s) begin
        cw_s = CW_IDLE;
      end else begin
        case (op4_s)
          OP_LDA:  cw_s = (estep_s == 32'd0) ? CW_ADDR : CW_MEM_A;
          OP_ADD:  cw_s = (estep_s == 32'd0) ? CW_ADDR :
                          (estep_s == 32'd1) ? CW_MEM_B : CW_ALU_A;
          OP_SUB:  cw_s = (estep_s == 32'd0) ? CW_ADDR :
                          (estep_s == 32'd1) ? CW_MEM_B : CW_ALU_SA;
          OP_STA:  cw_s = (estep_s == 32'd0) ? CW_ADDR : CW_STORE;
          OP_LDI:  cw_s = CW_IMM_A;
          OP_JMP:  cw_s = CW_JUMP;
          OP_JC:   cw_s = flag_c ? CW_JUMP : CW_IDLE;
          OP_JZ:   cw_s = flag_z ? CW_JUMP : CW_IDLE;
          OP_OUT:  cw_s = CW_OUTPUT;
          OP_HLT: begin
            cw_s        = CW_HALT;
            done_s      = 1'b0;
            halt_step_s = 1'b1;
          end
          default: cw_s = CW_IDLE;
        endcase
      end
    end
  end

  // Output gating: reset and stall force idle, halt holds the HLT line.
  always_comb begin
    con_word   = {CW_W{1'b0}};
    instr_done = 1'b0;
    if (rst) begin
      con_word   = {CW_W{1'b0}};
      instr_done = 1'b0;
    end else if (halted_r) begin
      con_word   = CW_W'(CW_HALT);
      instr_done = 1'b0;
    end else if (run) begin
      con_word   = CW_W'(cw_s);
      instr_done = done_s;
    end else begin
      con_word   = {CW_W{1'b0}};
      instr_done = 1'b0;
    end
  end

  // Sticky halt flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      halted_r <= 1'b0;
    end else if (adv_s && halt_step_s) begin
      halted_r <= 1'b1;
    end else begin
      halted_r <= halted_r;
    end
  end

  assign t_state = t_state_s;
  assign halted  = halted_r;

endmodule

// File: tb/tb_microcoded_sequencer.sv
// Directed bench for microcoded_sequencer with hand-computed control words.
module tb_microcoded_sequencer;

  logic        clk;
  logic        rst;
  logic        run;
  logic [3:0]  opcode;
  logic        flag_c;
  logic        flag_z;
  logic [15:0] con_word;
  logic [5:0]  t_state;
  logic        instr_done;
  logic        halted;

  int errors = 0;
  int checks = 0;

  microcoded_sequencer #(.CW_W(16), .OP_W(4), .T_MAX(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .opcode     (opcode),
    .flag_c     (flag_c),
    .flag_z     (flag_z),
    .con_word   (con_word),
    .t_state    (t_state),
    .instr_done (instr_done),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic at(input string tag, input logic [15:0] cw, input logic [5:0] ts,
                    input logic d, input logic h);
    #1;
    chk({tag, ".cw"},   32'(con_word),   32'(cw));
    chk({tag, ".ts"},   32'(t_state),    32'(ts));
    chk({tag, ".done"}, 32'(instr_done), 32'(d));
    chk({tag, ".halt"}, 32'(halted),     32'(h));
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic fetch(input string tag);
    at({tag, ".T1"}, 16'h000A, 6'h01, 1'b0, 1'b0);
    tick();
    at({tag, ".T2"}, 16'h0051, 6'h02, 1'b0, 1'b0);
    tick();
  endtask

  task automatic back_to_t1(input string tag);
    tick();
    at({tag, ".ret"}, 16'h000A, 6'h01, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; opcode = 4'h0; flag_c = 1'b0; flag_z = 1'b0;
    tick();
    tick();
    at("reset", 16'h0000, 6'h01, 1'b0, 1'b0);
    rst = 1'b0; run = 1'b1;

    // LDA
    fetch("lda");
    at("lda.E1", 16'h0088, 6'h04, 1'b0, 1'b0); tick();
    at("lda.E2", 16'h0110, 6'h08, 1'b1, 1'b0);
    back_to_t1("lda");

    // ADD then SUB
    opcode = 4'h1;
    fetch("add");
    at("add.E1", 16'h0088, 6'h04, 1'b0, 1'b0); tick();
    at("add.E2", 16'h0410, 6'h08, 1'b0, 1'b0); tick();
    at("add.E3", 16'h0900, 6'h10, 1'b1, 1'b0);
    back_to_t1("add");
    opcode = 4'h2;
    fetch("sub");
    at("sub.E1", 16'h0088, 6'h04, 1'b0, 1'b0); tick();
    at("sub.E2", 16'h0410, 6'h08, 1'b0, 1'b0); tick();
    at("sub.E3", 16'h1900, 6'h10, 1'b1, 1'b0);
    back_to_t1("sub");

    // Conditional jumps; each jump looks only at its own flag
    opcode = 4'h6; flag_c = 1'b1; flag_z = 1'b0;
    fetch("jc1");
    at("jc1.E1", 16'h0084, 6'h04, 1'b1, 1'b0);
    back_to_t1("jc1");
    flag_c = 1'b0; flag_z = 1'b1;
    fetch("jc0");
    at("jc0.E1", 16'h0000, 6'h04, 1'b1, 1'b0);
    back_to_t1("jc0");
    opcode = 4'h7; flag_c = 1'b0; flag_z = 1'b1;
    fetch("jz1");
    at("jz1.E1", 16'h0084, 6'h04, 1'b1, 1'b0);
    back_to_t1("jz1");
    flag_c = 1'b1; flag_z = 1'b0;
    fetch("jz0");
    at("jz0.E1", 16'h0000, 6'h04, 1'b1, 1'b0);
    back_to_t1("jz0");

    // Stall during ADD E2
    opcode = 4'h1;
    fetch("stall");
    at("stall.E1", 16'h0088, 6'h04, 1'b0, 1'b0); tick();
    at("stall.E2", 16'h0410, 6'h08, 1'b0, 1'b0);
    run = 1'b0;
    at("stall.hold0", 16'h0000, 6'h08, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      at("stall.hold", 16'h0000, 6'h08, 1'b0, 1'b0);
    end
    run = 1'b1;
    at("stall.reissue", 16'h0410, 6'h08, 1'b0, 1'b0); tick();
    at("stall.E3", 16'h0900, 6'h10, 1'b1, 1'b0);
    back_to_t1("stall");

    // LDI, JMP, OUT
    opcode = 4'h4;
    fetch("ldi");
    at("ldi.E1", 16'h0180, 6'h04, 1'b1, 1'b0);
    back_to_t1("ldi");
    opcode = 4'h5;
    fetch("jmp");
    at("jmp.E1", 16'h0084, 6'h04, 1'b1, 1'b0);
    back_to_t1("jmp");
    opcode = 4'hE;
    fetch("out");
    at("out.E1", 16'h2200, 6'h04, 1'b1, 1'b0);
    back_to_t1("out");

    // HLT and sticky halt
    opcode = 4'hF;
    fetch("hlt");
    at("hlt.E1", 16'h4000, 6'h04, 1'b0, 1'b0); tick();
    at("hlt.enter", 16'h4000, 6'h00, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      run = i[0];
      tick();
      at("hlt.hold", 16'h4000, 6'h00, 1'b0, 1'b1);
    end
    run = 1'b1; rst = 1'b1;
    at("hlt.rst_hi", 16'h0000, 6'h00, 1'b0, 1'b1);
    tick();
    at("hlt.rst_edge", 16'h0000, 6'h01, 1'b0, 1'b0);
    rst = 1'b0;
    at("hlt.exit", 16'h000A, 6'h01, 1'b0, 1'b0);

    // Reset mid-STA, then complete STA
    opcode = 4'h3;
    fetch("sta_rst");
    at("sta_rst.E1", 16'h0088, 6'h04, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    at("sta_rst.after", 16'h000A, 6'h01, 1'b0, 1'b0);
    fetch("sta");
    at("sta.E1", 16'h0088, 6'h04, 1'b0, 1'b0); tick();
    at("sta.E2", 16'h0220, 6'h08, 1'b1, 1'b0);
    back_to_t1("sta");

    // Undefined opcode acts as a one-step NOP
    opcode = 4'hA;
    fetch("nop");
    at("nop.E1", 16'h0000, 6'h04, 1'b1, 1'b0);
    back_to_t1("nop");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/microcoded_sequencer.md
Name: microcoded_sequencer

Overview:
- Next-generation control sequencer for the SAP-class CPU.
- Drives all datapath enables from a one-hot T-state ring, using the IR opcode and ALU flags.
- New relative to the current generation:
  - parametrised control-word width and ring depth
  - variable-length instructions with early return to fetch
  - conditional jumps (JC/JZ)
  - STA/LDI/JMP support
  - a run/stall input
  - a sticky halted state
- Sits between the instruction register / flag register and every datapath load/output enable.

Parameters:
- CW_W, 16, control word width; must be ≥15; bits above 14 are driven 0.
- OP_W, 4, opcode width; opcode constants use the low 4 bits, upper bits must be 0 to decode.
- T_MAX, 6, ring length in T-states; must be ≥5 (longest instruction); unused positions are never entered.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- run  in  1  step enable; 0 freezes the sequencer.
- opcode  in  OP_W  IR upper nibble, valid from T3 onward.
- flag_c  in  1  ALU carry flag, sampled combinationally during the jump step.
- flag_z  in  1  ALU zero flag, sampled combinationally during the jump step.
- con_word  out  CW_W  active-high control word.
- t_state  out  T_MAX  one-hot current T-state (bit0 = T1).
- instr_done  out  1  high during the final step of each instruction.
- halted  out  1  sticky halt indicator.

Behaviour:
- Control word bits: 0 PC_INC, 1 PC_OUT, 2 PC_LD, 3 MAR_LD, 4 RAM_OUT, 5 RAM_IN, 6 IR_LD, 7 IR_OUT, 8 A_LD, 9 A_OUT, 10 B_LD, 11 ALU_OUT, 12 ALU_SUB, 13 OUT_LD, 14 HLT. Idle word = all zeros.
- Reset:
  - t_state = 1 (T1), halted = 0.
  - con_word = 0 and instr_done = 0 while rst is high.
  - rst overrides run and halted. Reset mid-instruction abandons it; the next cycle is T1.
- State register:
  - Advances only on a rising edge with run=1 and halted=0.
  - run=0: t_state is held, con_word = 0, instr_done = 0. On resume, the same step is re-issued.
- con_word and instr_done are combinational from t_state, opcode and flags (Moore plus opcode decode); no added latency.
- Fetch:
  - T1 = PC_OUT|MAR_LD (0x000A).
  - T2 = RAM_OUT|IR_LD|PC_INC (0x0051).
- Execute steps (E1 = T3). The step marked "done" asserts instr_done; the next edge loads T1.
  - LDA 0000: E1 IR_OUT|MAR_LD 0x0088; E2 RAM_OUT|A_LD 0x0110, done.
  - ADD 0001: E1 0x0088; E2 RAM_OUT|B_LD 0x0410; E3 ALU_OUT|A_LD 0x0900, done.
  - SUB 0010: as ADD, but E3 adds ALU_SUB (0x1900), done.
  - STA 0011: E1 0x0088; E2 A_OUT|RAM_IN 0x0220, done.
  - LDI 0100: E1 IR_OUT|A_LD 0x0180, done.
  - JMP 0101: E1 IR_OUT|PC_LD 0x0084, done.
  - JC 0110: E1 0x0084 if flag_c else 0x0000, done either way.
  - JZ 0111: E1 0x0084 if flag_z else 0x0000, done either way.
  - OUT 1110: E1 A_OUT|OUT_LD 0x2200, done.
  - HLT 1111: E1 HLT 0x4000.
  - Any other opcode: E1 0x0000 (NOP), done.
- Halt:
  - On the edge leaving HLT E1 (run=1): halted <= 1, t_state <= 0.
  - While halted: con_word = 0x4000, instr_done = 0.
  - Only rst exits halt.
- Robustness: any t_state that is not one-hot, or reached beyond the current instruction's length, is forced to T1 on the next enabled edge; con_word = 0 meanwhile.
- Opcode changes are only legal at the T2→T3 edge; behaviour under other changes is not required.

Decomposition:
- Package seq_pkg holds:
  - opcode localparams
  - CW bit index constants
  - CW_IDLE and CW_FETCH1/CW_FETCH2 constants
  - minimum-width checks
- Sub-module seq_ring_counter(T_MAX):
  - one-hot ring with sync reset-to-T1, hold (enable low), load-T1 (done or illegal), and clear-to-zero (halt).
- Top level: microcode decode plus halt flag.

Test Plan:
- rst high 2 cycles, then run=1, opcode=0000 (LDA) → con_word sequence 0x000A, 0x0051, 0x0088, 0x0110 (instr_done=1), then 0x000A on the next cycle.
- ADD then SUB back to back → E3 words 0x0900 and 0x1900; each instruction takes 5 cycles; t_state goes 1,2,4,8,16,1.
- JC with flag_c=1 → E1 0x0084; with flag_c=0 → E1 0x0000; both return to T1 after 3 cycles. Repeat for JZ/flag_z.
- run=0 during ADD E2 for 3 cycles → con_word 0, t_state held at 0x08; after run=1 → 0x0410 re-issued, then 0x0900.
- HLT (1111) → E1 0x4000, then halted=1, t_state=0, con_word stays 0x4000 for 10+ cycles regardless of run. rst → T1, 0x000A.
- rst asserted during STA E1 → next cycle t_state=1, halted=0. Opcode 1010 → NOP, 3-cycle instruction, E1 0x0000.
